lenet_axil_regif: RTL and testbench

AXI4-Lite slave register interface in front of the LeNet core. It decodes the register map used by software, turns writes to the weight, bias and fmap push registers into a single valid/ready word stream with a channel select, and latches the core's done flag and classification result for polling.

---
 rtl/lenet_axil_regif.sv | 207 ++++++++++++++++++++
 tb/tb_lenet_axil_regif.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_axil_regif.sv
// lenet_axil_regif: AXI4-Lite register front end for the LeNet core.
// Optional STREAM_COUNT_EN adds per-channel accepted-word counters at 0x10.
module lenet_axil_regif #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int RESULT_WIDTH       = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          o_run,
  output logic                          o_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_stream_data,
  output logic [1:0]                    o_stream_sel,
  output logic                          o_stream_valid,
  input  logic                          i_stream_ready,
  input  logic                          i_done,
  input  logic [RESULT_WIDTH-1:0]       i_result
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PUSH = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_WEIGHT = 3'd1;
  localparam logic [2:0] A_BIAS   = 3'd2;
  localparam logic [2:0] A_FMAP   = 3'd3;
  localparam logic [2:0] A_COUNT  = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_RESULT = 3'd6;
  localparam logic [2:0] A_CLEAR  = 3'd7;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [2:0] aw_idx, ar_idx;
  logic       aw_push, aw_hs, ar_hs;
  logic       run_q, clear_q, done_q, done_d, done_clr;
  logic [RESULT_WIDTH-1:0]       result_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] sdata_q, rdata_q, rdata_d;
  logic [1:0]  ssel_q;
  logic [31:0] count_word;
  logic        unused_ok;

  assign aw_idx  = S_AXI_AWADDR[4:2];
  assign ar_idx  = S_AXI_ARADDR[4:2];
  assign aw_push = (aw_idx == A_WEIGHT) || (aw_idx == A_BIAS) ||
                   (aw_idx == A_FMAP);
  assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign done_clr = aw_hs &&
    (((aw_idx == A_CTRL) && !S_AXI_WDATA[0]) ||
     ((aw_idx == A_CLEAR) && S_AXI_WDATA[0]));

  // Write channel next state; address and data accepted together in idle
  always_comb begin
    wstate_d = wstate_q;
    aw_hs    = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        aw_hs = S_AXI_AWVALID & S_AXI_WVALID;
        if (aw_hs)
          wstate_d = (aw_push && !clear_q) ? W_PUSH : W_RESP;
      end
      W_PUSH: if (i_stream_ready) wstate_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write channel state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wstate_q <= W_IDLE;
    else                wstate_q <= wstate_d;
  end

  assign S_AXI_AWREADY  = aw_hs;
  assign S_AXI_WREADY   = aw_hs;
  assign S_AXI_BVALID   = (wstate_q == W_RESP);
  assign S_AXI_BRESP    = 2'b00;
  assign o_stream_valid = (wstate_q == W_PUSH);
  assign o_stream_data  = sdata_q;
  assign o_stream_sel   = ssel_q;
  assign o_run          = run_q;
  assign o_clear        = clear_q;

  // Done flag: a core pulse overrides a same-cycle software clear
  always_comb begin
    done_d = done_q;
    if (done_clr) done_d = 1'b0;
    if (i_done)   done_d = 1'b1;
  end

  // Control registers, push word latch and result capture
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      run_q    <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sdata_q  <= '0;
      ssel_q   <= 2'b00;
    end else begin
      if (aw_hs && (aw_idx == A_CTRL))  run_q   <= S_AXI_WDATA[0];
      if (aw_hs && (aw_idx == A_CLEAR)) clear_q <= S_AXI_WDATA[0];
      if (aw_hs && aw_push) begin
        sdata_q <= S_AXI_WDATA;
        ssel_q  <= aw_idx[1:0] - 2'd1;
      end
      done_q <= done_d;
      if (i_done) result_q <= i_result;
    end
  end

`ifdef STREAM_COUNT_EN
  logic [11:0] wcnt_q, bcnt_q, fcnt_q;
  logic        s_fire, cnt_clr;

  assign s_fire  = o_stream_valid & i_stream_ready;
  assign cnt_clr = aw_hs &&
    (((aw_idx == A_CLEAR) && S_AXI_WDATA[0]) ||
     ((aw_idx == A_CTRL) && S_AXI_WDATA[0] && !run_q));
  assign count_word = {4'b0, bcnt_q[3:0], fcnt_q, wcnt_q};

  // Saturating per-channel counts of words the core accepted
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wcnt_q <= '0;
      bcnt_q <= '0;
      fcnt_q <= '0;
    end else if (cnt_clr) begin
      wcnt_q <= '0;
      bcnt_q <= '0;
      fcnt_q <= '0;
    end else if (s_fire) begin
      unique case (1'b1)
        (ssel_q == 2'b00): if (wcnt_q != 12'hFFF) wcnt_q <= wcnt_q + 12'd1;
        (ssel_q == 2'b01): if (bcnt_q != 12'hFFF) bcnt_q <= bcnt_q + 12'd1;
        default:           if (fcnt_q != 12'hFFF) fcnt_q <= fcnt_q + 12'd1;
      endcase
    end
  end
`else
  assign count_word = '0;
`endif

  assign ar_hs = (rstate_q == R_IDLE) & S_AXI_ARVALID;

  // Read channel next state and register read mux
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = '0;
    unique case (rstate_q)
      R_IDLE: if (ar_hs) rstate_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    unique case (ar_idx)
      A_CTRL:   rdata_d[0] = run_q;
      A_COUNT:  rdata_d    = count_word;
      A_STATUS: rdata_d[0] = done_q;
      A_RESULT: rdata_d[RESULT_WIDTH-1:0] = result_q;
      A_CLEAR:  rdata_d[0] = clear_q;
      default:  rdata_d    = '0;
    endcase
  end

  // Read channel state and data, data held until accepted
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) rdata_q <= rdata_d;
    end
  end

  assign S_AXI_ARREADY = ar_hs;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_lenet_axil_regif.sv
// tb_lenet_axil_regif: randomized AXI-Lite traffic against a register model.
// Build with STREAM_COUNT_EN to also cover the stream counters.
module tb_lenet_axil_regif;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp, ssel;
  logic [31:0] rdata, sdata;
  logic        o_run, o_clear, svalid;
  logic        sready = 0, i_done = 0;
  logic [3:0]  i_result = '0;

  always #5 clk = ~clk;

  lenet_axil_regif dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .o_run(o_run), .o_clear(o_clear), .o_stream_data(sdata),
    .o_stream_sel(ssel), .o_stream_valid(svalid),
    .i_stream_ready(sready), .i_done(i_done), .i_result(i_result)
  );

  int n_chk = 0, n_err = 0;

  // reference model of software-visible state
  bit       m_run, m_clr, m_done;
  int       m_res, m_cw, m_cb, m_cf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    m_run = 0; m_clr = 0; m_done = 0; m_res = 0;
    m_cw = 0; m_cb = 0; m_cf = 0;
  endfunction

  function automatic void m_cnt_clr();
    m_cw = 0; m_cb = 0; m_cf = 0;
  endfunction

  function automatic int sat(input int v);
    return (v < 4095) ? v + 1 : 4095;
  endfunction

  function automatic logic [31:0] m_read(input int i);
    int r;
    r = 0;
    case (i)
      0: r = int'(m_run);
`ifdef STREAM_COUNT_EN
      4: r = (m_cb % 16) * (1 << 24) + m_cf * (1 << 12) + m_cw;
`endif
      5: r = int'(m_done);
      6: r = m_res;
      7: r = int'(m_clr);
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  function automatic void m_write(input int i, input logic [31:0] d);
    if (i == 0) begin
      if (!d[0]) m_done = 0;
      if (d[0] && !m_run) m_cnt_clr();
      m_run = d[0];
    end else if (i == 7) begin
      m_clr = d[0];
      if (d[0]) begin
        m_done = 0;
        m_cnt_clr();
      end
    end
  endfunction

  task automatic axi_wr(input int i, input logic [31:0] d,
                        input int stall, input int bstall);
    int  n;
    bit  push;
    n = 0;
    push = (i >= 1 && i <= 3) && !m_clr;
    awaddr = 5'(i * 4); wdata = d; awvalid = 1; wvalid = 1;
    #1;
    while (!(awready && wready) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    chk("aw_handshake", 32'(n < 20), 1);
    tick();
    awvalid = 0; wvalid = 0;
    #1;
    if (push) begin
      for (int k = 0; k < stall; k++) begin
        chk("push_valid", 32'(svalid), 1);
        chk("push_data", sdata, d);
        chk("push_sel", 32'(ssel), 32'(i - 1));
        chk("push_no_b", 32'(bvalid), 0);
        tick(); #1;
      end
      chk("push_valid", 32'(svalid), 1);
      chk("push_data", sdata, d);
      chk("push_sel", 32'(ssel), 32'(i - 1));
      sready = 1;
      tick();
      sready = 0;
      #1;
      chk("push_drop_valid", 32'(svalid), 0);
      if (i == 1) m_cw = sat(m_cw);
      if (i == 2) m_cb = sat(m_cb);
      if (i == 3) m_cf = sat(m_cf);
    end else begin
      chk("no_push", 32'(svalid), 0);
      m_write(i, d);
    end
    chk("bvalid", 32'(bvalid), 1);
    chk("bresp", 32'(bresp), 0);
    for (int k = 0; k < bstall; k++) begin
      tick(); #1;
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("bresp_hold", 32'(bresp), 0);
      chk("awready_hold", 32'(awready), 0);
    end
    bready = 1;
    tick();
    bready = 0;
    #1;
    chk("b_done", 32'(bvalid), 0);
  endtask

  task automatic axi_rd(input int i, input int rstall, output logic [31:0] d);
    int n;
    logic [31:0] exp;
    n = 0;
    exp = m_read(i);
    araddr = 5'(i * 4); arvalid = 1;
    #1;
    while (!arready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    chk("ar_handshake", 32'(n < 20), 1);
    tick();
    arvalid = 0;
    #1;
    chk("rvalid", 32'(rvalid), 1);
    chk("rresp", 32'(rresp), 0);
    d = rdata;
    for (int k = 0; k < rstall; k++) begin
      tick(); #1;
      chk("rvalid_hold", 32'(rvalid), 1);
      chk($sformatf("rdata_hold_%0d", i), rdata, exp);
      chk("arready_hold", 32'(arready), 0);
    end
    rready = 1;
    tick();
    rready = 0;
    #1;
    chk("r_done", 32'(rvalid), 0);
  endtask

  task automatic rd_chk(input int i, input int rstall);
    logic [31:0] exp, got;
    exp = m_read(i);
    axi_rd(i, rstall, got);
    chk($sformatf("read_%0d", i), got, exp);
  endtask

  task automatic pulse_done(input int r);
    i_done = 1; i_result = 4'(r);
    tick();
    i_done = 0;
    m_done = 1; m_res = r;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int op, a;
    m_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_run", 32'(o_run), 0);
    chk("rst_clear", 32'(o_clear), 0);
    chk("rst_svalid", 32'(svalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    rst_n = 1;
    tick();

    // reset asserted while a push is waiting on the core
    awaddr = 5'h04; wdata = 32'h12345678; awvalid = 1; wvalid = 1;
    #1;
    chk("mid_aw", 32'(awready), 1);
    tick();
    awvalid = 0; wvalid = 0;
    tick(); #1;
    chk("mid_push_valid", 32'(svalid), 1);
    #1 rst_n = 0;
    #1;
    chk("rst_async_svalid", 32'(svalid), 0);
    chk("rst_async_bvalid", 32'(bvalid), 0);
    repeat (2) tick();
    rst_n = 1;
    m_reset();
    tick();
    chk("post_rst_bvalid", 32'(bvalid), 0);
    rd_chk(5, 0);
    rd_chk(6, 0);

    // push held off by the core for five cycles
    axi_wr(1, 32'hDEADBEEF, 5, 0);

    // done latch and result retention
    axi_wr(0, 1, 0, 0);
    pulse_done(7);
    rd_chk(5, 0);
    rd_chk(6, 0);
    axi_wr(0, 0, 0, 0);
    rd_chk(5, 0);
    rd_chk(6, 0);

    // pushes dropped while clear is held
    axi_wr(7, 1, 0, 0);
    chk("clear_level", 32'(o_clear), 1);
    axi_wr(3, 32'h55, 2, 0);
    axi_wr(7, 0, 0, 0);

    // response channels stalled by the master
    axi_wr(0, 1, 0, 3);
    rd_chk(0, 3);

    // read issued in the cycle done sets sees the old flag
    axi_wr(0, 0, 0, 0);
    araddr = 5'h14; arvalid = 1; i_done = 1; i_result = 4'd3;
    #1;
    chk("same_cycle_ar", 32'(arready), 1);
    tick();
    arvalid = 0; i_done = 0;
    m_done = 1; m_res = 3;
    #1;
    chk("same_cycle_old_done", rdata, 0);
    rready = 1; tick(); rready = 0; #1;
    rd_chk(5, 0);

    // done set wins over a same-cycle run=0 clear
    awaddr = 5'h00; wdata = 0; awvalid = 1; wvalid = 1;
    i_done = 1; i_result = 4'd9;
    #1;
    chk("set_wins_aw", 32'(awready), 1);
    tick();
    awvalid = 0; wvalid = 0; i_done = 0;
    m_run = 0; m_done = 1; m_res = 9;
    #1;
    chk("set_wins_b", 32'(bvalid), 1);
    bready = 1; tick(); bready = 0; #1;
    rd_chk(5, 0);
    rd_chk(6, 0);

    // randomized mix of writes, pushes, reads and done pulses
    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: axi_wr(0, 32'($urandom_range(0, 1)), 0, $urandom_range(0, 2));
        1: axi_wr(7, 32'($urandom_range(0, 3) == 0), 0, $urandom_range(0, 2));
        2, 3, 4: axi_wr($urandom_range(1, 3), $urandom, $urandom_range(0, 3),
                        $urandom_range(0, 2));
        5, 6, 7: begin
          a = $urandom_range(0, 7);
          rd_chk(a, $urandom_range(0, 2));
        end
        default: pulse_done($urandom_range(0, 15));
      endcase
    end
    axi_wr(7, 0, 0, 0);

`ifdef STREAM_COUNT_EN
    axi_wr(7, 1, 0, 0);
    axi_wr(7, 0, 0, 0);
    for (int k = 0; k < 3220; k++) axi_wr(1, $urandom, 0, 0);
    for (int k = 0; k < 10; k++)   axi_wr(2, $urandom, 0, 0);
    for (int k = 0; k < 784; k++)  axi_wr(3, $urandom, 0, 0);
    axi_rd(4, 0, d);
    chk("count_total", d, 32'h0A310C94);
    axi_wr(0, 1, 0, 0);
    rd_chk(4, 0);
`else
    rd_chk(4, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
